// File: rtl/cal_eep_pkg.sv
// Shared definitions for the calibration EEPROM SPI responder.
// Holds the frame width, the frame opcodes and the responder state encoding.
package cal_eep_pkg;

    localparam int unsigned FRAME_W = 16;

    localparam logic [1:0] EEP_OP_RD  = 2'b00;
    localparam logic [1:0] EEP_OP_WRT = 2'b01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DECODE = 2'd2
    } eep_state_t;

endpackage

// File: rtl/spi_resp_sync.sv
// Brings the SPI pins into the clk domain and derives edge strobes.
// Ports:
//   clk, rst_n             system clock, async active-low reset
//   ss_n, sclk, mosi       raw SPI pins (asynchronous to clk)
//   sclk_rise, sclk_fall   one-clk strobes on synchronized SCLK edges
//   ss_fall, ss_rise       one-clk strobes on synchronized SS_n edges
//   ss_act                 synchronized SS_n is low, after it was once seen high
//   mosi_s                 synchronized MOSI, aligned with the SCLK strobes
module spi_resp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ss_n,
    input  logic sclk,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_fall,
    output logic ss_rise,
    output logic ss_act,
    output logic mosi_s
);

    // [0],[1] synchronizer, [2] edge-detect history
    logic [2:0] ss_sync;
    logic [2:0] sclk_sync;
    logic [1:0] mosi_sync;
    logic       ss_armed;

    // SS_n history resets low so a frame already in progress at reset
    // release never produces a falling edge; SCLK resets to its idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync   <= 3'b000;
            sclk_sync <= 3'b111;
            mosi_sync <= 2'b00;
            ss_armed  <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[1:0], ss_n};
            sclk_sync <= {sclk_sync[1:0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
            ss_armed  <= ss_armed | ss_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign ss_rise   = ss_sync[1] & ~ss_sync[2];
    assign ss_fall   = ~ss_sync[1] & ss_sync[2];
    assign ss_act    = ~ss_sync[1] & ss_armed;
    assign mosi_s    = mosi_sync[1];

endmodule

// File: rtl/cal_eep_spi_resp.sv
// SPI responder standing in for the calibration EEPROM on the command
// processor's EEPROM channel. 16-bit frames: {op[1:0], addr[5:0], data[7:0]}.
// Write commits to a 64x8 store; read data is returned during the next frame.
// Ports:
//   clk, rst_n      system clock, async active-low reset
//   SS_n, SCLK      chip select (active low) and SPI clock (idles high)
//   MOSI, MISO      serial data, MSB first
//   MISO_oe         high while synchronized SS_n is low
//   wrt_done        one-clk pulse when a write is committed
//   rd_done         one-clk pulse when read data is loaded for the next frame
//   dbg_addr/data   address and data of the last completed valid frame
module cal_eep_spi_resp
    import cal_eep_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_oe,
    output logic              wrt_done,
    output logic              rd_done,
    output logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

    logic sclk_rise;
    logic sclk_fall;
    logic ss_fall;
    logic ss_rise;
    logic ss_act;
    logic mosi_s;

    eep_state_t         state;
    eep_state_t         state_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-1:0] rx_shft;
    logic [FRAME_W-1:0] tx_shft;
    logic [DATA_W-1:0]  store [DEPTH];
    logic               fall_pend;
    logic               start_frame;

    logic [1:0]         opcode;
    logic [ADDR_W-1:0]  rx_addr;
    logic [DATA_W-1:0]  rx_data;
    logic               store_we;

    spi_resp_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .ss_n      (SS_n),
        .sclk      (SCLK),
        .mosi      (MOSI),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_fall   (ss_fall),
        .ss_rise   (ss_rise),
        .ss_act    (ss_act),
        .mosi_s    (mosi_s)
    );

    assign opcode      = rx_shft[FRAME_W-1 -: 2];
    assign rx_addr     = rx_shft[DATA_W +: ADDR_W];
    assign rx_data     = rx_shft[DATA_W-1:0];
    assign store_we    = (state == DECODE) && (opcode == EEP_OP_WRT);
    // A select that lands during DECODE is held one clk so IDLE still sees it
    assign start_frame = ss_fall | fall_pend;
    assign MISO        = tx_shft[FRAME_W-1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_frame) state_nxt = SHIFT;
            SHIFT:   if (ss_rise) state_nxt = (bit_cnt == CNT_FULL) ? DECODE : IDLE;
            DECODE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame shifting, decode and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            rx_shft   <= '0;
            tx_shft   <= '0;
            fall_pend <= 1'b0;
            wrt_done  <= 1'b0;
            rd_done   <= 1'b0;
            dbg_addr  <= '0;
            dbg_data  <= '0;
            MISO_oe   <= 1'b0;
        end else begin
            wrt_done  <= 1'b0;
            rd_done   <= 1'b0;
            MISO_oe   <= ss_act;
            fall_pend <= (state == DECODE) && ss_fall;
            case (state)
                IDLE: begin
                    if (start_frame) begin
                        bit_cnt <= '0;
                        rx_shft <= '0;
                    end
                end
                SHIFT: begin
                    // Count saturates: edges past a full frame are ignored
                    if (sclk_rise && (bit_cnt != CNT_FULL)) begin
                        rx_shft <= {rx_shft[FRAME_W-2:0], mosi_s};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                    // First fall only leaves idle-high; MSB is already on MISO
                    if (sclk_fall && (bit_cnt != '0)) begin
                        tx_shft <= {tx_shft[FRAME_W-2:0], 1'b0};
                    end
                    if (ss_rise && (bit_cnt != CNT_FULL)) begin
                        tx_shft <= '0;
                    end
                end
                DECODE: begin
                    case (opcode)
                        EEP_OP_WRT: begin
                            wrt_done <= 1'b1;
                            dbg_addr <= rx_addr;
                            dbg_data <= rx_data;
                            tx_shft  <= '0;
                        end
                        EEP_OP_RD: begin
                            rd_done  <= 1'b1;
                            dbg_addr <= rx_addr;
                            dbg_data <= store[rx_addr];
                            tx_shft  <= FRAME_W'(store[rx_addr]);
                        end
                        default: begin
                            tx_shft <= '0;
                        end
                    endcase
                end
                default: begin
                    tx_shft <= '0;
                end
            endcase
        end
    end

    // Calibration store, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else if (store_we) begin
            store[rx_addr] <= rx_data;
        end
    end

endmodule

// File: tb/tb_cal_eep_spi_resp.sv
// Directed bench for the calibration EEPROM SPI responder. A behavioural
// EEPROM model predicts MISO words, pulses and debug values per frame.
module tb_cal_eep_spi_resp;

    typedef struct packed {
        logic [1:0] pulse;   // {wrt_done, rd_done} expected 4 clk after SS_n rise
        logic [5:0] addr;
        logic [7:0] data;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       SCLK;
    logic       MOSI;
    logic       MISO;
    logic       MISO_oe;
    logic       wrt_done;
    logic       rd_done;
    logic [5:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mdl [64];
    logic [15:0] mdl_tx;
    logic [5:0]  mdl_dbg_addr;
    logic [7:0]  mdl_dbg_data;
    logic [31:0] exp_miso_q [$];
    evt_t        exp_evt_q [$];

    always #5 clk = ~clk;

    cal_eep_spi_resp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .MISO_oe  (MISO_oe),
        .wrt_done (wrt_done),
        .rd_done  (rd_done),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
        mdl_tx       = 16'h0000;
        mdl_dbg_addr = 6'h00;
        mdl_dbg_data = 8'h00;
    endtask

    // One SPI frame of n bits (MSB first from bits[n-1]), SCLK half-period in clk
    task automatic spi_frame(input logic [31:0] bits, input int n, input int half, input int gap);
        logic [31:0] got;
        logic [31:0] exp_m;
        logic [15:0] w;
        logic [15:0] tx_next;
        evt_t        ev;
        evt_t        exp_ev;

        exp_m   = (n <= 16) ? (32'(mdl_tx) >> (16 - n)) : (32'(mdl_tx) << (n - 16));
        exp_miso_q.push_back(exp_m);
        tx_next  = 16'h0000;
        ev.pulse = 2'b00;
        if (n >= 16) begin
            w = 16'(bits >> (n - 16));
            case (w[15:14])
                2'b01: begin
                    mdl[w[13:8]] = w[7:0];
                    mdl_dbg_addr = w[13:8];
                    mdl_dbg_data = w[7:0];
                    ev.pulse     = 2'b10;
                end
                2'b00: begin
                    tx_next      = {8'h00, mdl[w[13:8]]};
                    mdl_dbg_addr = w[13:8];
                    mdl_dbg_data = mdl[w[13:8]];
                    ev.pulse     = 2'b01;
                end
                default: ;
            endcase
        end
        mdl_tx  = tx_next;
        ev.addr = mdl_dbg_addr;
        ev.data = mdl_dbg_data;
        exp_evt_q.push_back(ev);

        got  = 32'h0;
        SS_n = 1'b0;
        repeat (half) @(negedge clk);
        check("miso_oe_selected", 32'(MISO_oe), 32'h1);
        for (int i = 0; i < n; i++) begin
            SCLK = 1'b0;
            MOSI = bits[n-1-i];
            repeat (half) @(negedge clk);
            got  = {got[30:0], MISO};
            SCLK = 1'b1;
            repeat (half) @(negedge clk);
        end
        SS_n = 1'b1;
        MOSI = 1'b0;

        exp_ev = exp_evt_q.pop_front();
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("pulse_k%0d", k), 32'({wrt_done, rd_done}),
                  32'((k == 4) ? exp_ev.pulse : 2'b00));
        end
        check("miso_word", got, exp_miso_q.pop_front());
        check("dbg_addr", 32'(dbg_addr), 32'(exp_ev.addr));
        check("dbg_data", 32'(dbg_data), 32'(exp_ev.data));
        check("miso_oe_deselected", 32'(MISO_oe), 32'h0);
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        logic [5:0] a;
        logic [7:0] d;
        logic       exp_bit;

        rst_n = 1'b0;
        SS_n  = 1'b1;
        SCLK  = 1'b1;
        MOSI  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(MISO), 32'h0);
        check("rst_miso_oe", 32'(MISO_oe), 32'h0);
        check("rst_pulses", 32'({wrt_done, rd_done}), 32'h0);
        check("rst_dbg_addr", 32'(dbg_addr), 32'h0);
        check("rst_dbg_data", 32'(dbg_data), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_miso_oe", 32'(MISO_oe), 32'h0);

        // Write, then read back through the following frame
        spi_frame(32'h4A3C, 16, 4, 2);
        spi_frame(32'h0A00, 16, 4, 2);
        spi_frame(32'h0000, 16, 4, 2);

        // Never-written top address
        spi_frame(32'h3F00, 16, 5, 2);
        spi_frame(32'h0000, 16, 4, 2);

        // Aborted after 9 bits of 16'h4155
        spi_frame(32'h4155 >> 7, 9, 4, 2);
        spi_frame(32'h0100, 16, 4, 2);
        spi_frame(32'h0000, 16, 4, 2);

        // Read followed by write: read data goes out during the write frame
        spi_frame(32'h4277, 16, 4, 2);
        spi_frame(32'h0200, 16, 4, 2);
        spi_frame(32'h4311, 16, 4, 2);
        spi_frame(32'h0300, 16, 4, 2);

        // Reserved opcode
        spi_frame(32'hC1FF, 16, 4, 2);
        spi_frame(32'h0100, 16, 4, 2);
        spi_frame(32'h0000, 16, 4, 2);

        // 18 clocks in a frame: extra edges ignored
        spi_frame({14'h0, 16'h4501, 2'b11}, 18, 4, 2);
        spi_frame(32'h0500, 16, 4, 2);
        spi_frame(32'h0000, 16, 4, 2);

        // Reset in the middle of a frame carrying read data
        spi_frame(32'h457E, 16, 4, 2);
        spi_frame(32'h0500, 16, 4, 2);
        exp_bit = mdl_tx[5];
        SS_n = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_miso_oe", 32'(MISO_oe), 32'h1);
        for (int i = 0; i < 10; i++) begin
            SCLK = 1'b0;
            repeat (4) @(negedge clk);
            SCLK = 1'b1;
            repeat (4) @(negedge clk);
        end
        SCLK = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_miso", 32'(MISO), 32'(exp_bit));
        rst_n = 1'b0;
        #1;
        check("mid_rst_miso", 32'(MISO), 32'h0);
        check("mid_rst_miso_oe", 32'(MISO_oe), 32'h0);
        check("mid_rst_dbg_data", 32'(dbg_data), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        SCLK = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            SCLK = 1'b0;
            MOSI = 1'b1;
            repeat (4) @(negedge clk);
            check("post_rst_miso_oe", 32'(MISO_oe), 32'h0);
            SCLK = 1'b1;
            repeat (4) @(negedge clk);
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("post_rst_pulse", 32'({wrt_done, rd_done}), 32'h0);
        end
        spi_frame(32'h0500, 16, 4, 2);
        spi_frame(32'h0000, 16, 4, 2);

        // Back-to-back write/read at minimum half-period and short deselect
        for (int i = 0; i < 4; i++) begin
            a = 6'(8 + i * 3);
            d = 8'($urandom_range(0, 255));
            spi_frame(32'({2'b01, a, d}), 16, 4, 0);
            spi_frame(32'({2'b00, a, 8'h00}), 16, 4, 0);
        end
        spi_frame(32'h0000, 16, 4, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
